// File: rtl/vector_sub_unit.sv
// ---------------------------------------------------------------------------
// vector_sub_unit
//
// Iterative SIMD subtractor. It computes a - b element-wise over LANES packed
// elements and handles one lane per clock. Operands arrive on a valid/ready
// handshake and results leave on one. Each lane can wrap or saturate. Each
// lane can be treated as unsigned or as signed two's-complement.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   operand vector valid
//   in_ready    out  unit can accept operands (high only in IDLE)
//   a_vec       in   minuend, lane i at [i*WIDTH +: WIDTH]
//   b_vec       in   subtrahend, same packing
//   sat         in   1 = saturate, 0 = wrap
//   sgn         in   1 = signed lanes, 0 = unsigned lanes
//   out_valid   out  result vector valid (high only in DONE)
//   out_ready   in   consumer accepts the result
//   result_vec  out  packed differences
//   borrow_vec  out  per lane: unsigned a < b
//   ovf_vec     out  per lane: signed overflow of a - b
//   zero_vec    out  per lane: final lane result == 0
// ---------------------------------------------------------------------------
module vector_sub_unit #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] a_vec,
  input  logic [LANES*WIDTH-1:0] b_vec,
  input  logic                   sat,
  input  logic                   sgn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result_vec,
  output logic [LANES-1:0]       borrow_vec,
  output logic [LANES-1:0]       ovf_vec,
  output logic [LANES-1:0]       zero_vec
);

  // With a single lane the counter still needs one bit.
  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(LANES - 1);
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One lane of the subtraction.
  // The result is packed as {zero, ovf, borrow, result}.
  // Borrow and overflow are always reported, whatever the sat/sgn mode.
  function automatic logic [WIDTH+2:0] lane_sub(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sat_m,
    input logic             sgn_m
  );
    logic [WIDTH:0]   d;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic             ovf;
    logic             zero;
    // The extra top bit of the (WIDTH+1)-bit difference is the unsigned borrow.
    d      = {1'b0, a} - {1'b0, b};
    borrow = d[WIDTH];
    // Signed overflow: the operand signs differ and the result sign differs from a.
    ovf    = (a[WIDTH-1] ^ b[WIDTH-1]) & (d[WIDTH-1] ^ a[WIDTH-1]);
    if (!sat_m) begin
      res = d[WIDTH-1:0];
    end else if (!sgn_m) begin
      res = borrow ? {WIDTH{1'b0}} : d[WIDTH-1:0];
    end else if (ovf) begin
      res = a[WIDTH-1] ? MIN_NEG : MAX_POS;
    end else begin
      res = d[WIDTH-1:0];
    end
    zero = (res == {WIDTH{1'b0}});
    return {zero, ovf, borrow, res};
  endfunction

  state_t                 r_state;
  logic [IDXW-1:0]        r_idx;
  logic [LANES*WIDTH-1:0] r_a;
  logic [LANES*WIDTH-1:0] r_b;
  logic                   r_sat;
  logic                   r_sgn;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [LANES*WIDTH-1:0] r_result;
  logic [LANES-1:0]       r_borrow;
  logic [LANES-1:0]       r_ovf;
  logic [LANES-1:0]       r_zero;

  logic [WIDTH-1:0]       w_a_lane;
  logic [WIDTH-1:0]       w_b_lane;
  logic [WIDTH+2:0]       w_lane;

  // Select the latched operand lane addressed by the lane counter and evaluate it.
  always_comb begin
    w_a_lane = r_a[r_idx*WIDTH +: WIDTH];
    w_b_lane = r_b[r_idx*WIDTH +: WIDTH];
    w_lane   = lane_sub(w_a_lane, w_b_lane, r_sat, r_sgn);
  end

  // Control FSM with its registered handshake outputs, operand latches and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= {IDXW{1'b0}};
      r_a         <= {(LANES*WIDTH){1'b0}};
      r_b         <= {(LANES*WIDTH){1'b0}};
      r_sat       <= 1'b0;
      r_sgn       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= {(LANES*WIDTH){1'b0}};
      r_borrow    <= {LANES{1'b0}};
      r_ovf       <= {LANES{1'b0}};
      r_zero      <= {LANES{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The previous results stay visible until a new vector is accepted.
          if (in_valid && r_in_ready) begin
            r_a        <= a_vec;
            r_b        <= b_vec;
            r_sat      <= sat;
            r_sgn      <= sgn;
            r_idx      <= {IDXW{1'b0}};
            r_result   <= {(LANES*WIDTH){1'b0}};
            r_borrow   <= {LANES{1'b0}};
            r_ovf      <= {LANES{1'b0}};
            r_zero     <= {LANES{1'b0}};
            r_in_ready <= 1'b0;
            r_state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_result[r_idx*WIDTH +: WIDTH] <= w_lane[WIDTH-1:0];
          r_borrow[r_idx]                <= w_lane[WIDTH];
          r_ovf[r_idx]                   <= w_lane[WIDTH+1];
          r_zero[r_idx]                  <= w_lane[WIDTH+2];
          if (r_idx == LAST_IDX) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        ST_DONE: begin
          // Hold everything under backpressure. in_ready only rises once IDLE is
          // reached, so a new vector cannot be accepted on the release edge.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign result_vec = r_result;
  assign borrow_vec = r_borrow;
  assign ovf_vec    = r_ovf;
  assign zero_vec   = r_zero;

endmodule
